// File: rtl/bcd_stopwatch_pkg.sv
// rtl/bcd_stopwatch_pkg.sv - shared state encodings and BCD constants for the stopwatch
package bcd_stopwatch_pkg;

  // Stopwatch operating states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_SPLIT   = 2'd2,
    ST_PAUSED  = 2'd3
  } sw_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;  // largest legal BCD digit value
  localparam int         DIGITS  = 4;     // SS.hh

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit, 0..9 with carry out on 9 -> 0
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to 0 (wins over inc)
//   inc         advance by one this cycle
//   q[3:0]      current digit
//   carry       combinational: high when inc wraps this digit from 9 to 0
module bcd_digit_counter
  import bcd_stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign carry = inc & ~clr & (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - BCD stopwatch engine (SS.hh) with pause, split and clear
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/stop/split/zero  debounced button levels, rising edge acts
//   displayed_time[15:0]   BCD {tens_s, s, tenths, hundredths}
//   running             1 in RUNNING or SPLIT
//   split_active        1 in SPLIT
//   overflow            sticky, set on 99.99 -> 00.00 wrap, cleared by zero
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        split,
  input  logic        zero,
  output logic [15:0] displayed_time,
  output logic        running,
  output logic        split_active,
  output logic        overflow
);

  localparam int              PRESCALE = CLK_HZ / TICK_HZ;
  localparam int              PS_W     = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);

  // Edge detection. History resets to 1 so a button held through reset
  // produces no edge when reset is released.
  logic [3:0] btn, btn_q, ev;
  logic       ev_start, ev_split, ev_stop, ev_zero;

  assign btn = {zero, stop, split, start};
  assign ev  = btn & ~btn_q;
  assign {ev_zero, ev_stop, ev_split, ev_start} = ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 4'b1111;
    else        btn_q <= btn;
  end

  // FSM
  sw_state_e state_q, state_d;
  logic      take_latch, clr_count, clr_ps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Each state checks only its legal edges, highest priority first, so
  // lower-priority simultaneous edges are dropped.
  always_comb begin
    state_d    = state_q;
    take_latch = 1'b0;
    clr_count  = 1'b0;
    clr_ps     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          state_d = ST_RUNNING;
          clr_ps  = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (ev_stop) begin
          state_d = ST_PAUSED;
        end else if (ev_split) begin
          state_d    = ST_SPLIT;
          take_latch = 1'b1;
        end
      end
      ST_SPLIT: begin
        if (ev_stop)       state_d = ST_PAUSED;
        else if (ev_split) state_d = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (ev_zero) begin
          state_d   = ST_IDLE;
          clr_count = 1'b1;
        end else if (ev_start) begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler: advances only while counting, holds its value in PAUSED so a
  // resume finishes the interrupted tick period.
  logic [PS_W-1:0] ps_q;
  logic            counting, tick;

  assign counting = (state_q == ST_RUNNING) || (state_q == ST_SPLIT);
  assign tick     = counting && (ps_q == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ps_q <= '0;
    else if (clr_ps || clr_count) ps_q <= '0;
    else if (tick)             ps_q <= '0;
    else if (counting)         ps_q <= ps_q + PS_W'(1);
  end

  // BCD digit chain: each digit increments on the carry of the one below.
  logic [DIGITS:0] inc_chain;
  logic [15:0]     count;

  assign inc_chain[0] = tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_count),
      .inc   (inc_chain[i]),
      .q     (count[4*i +: 4]),
      .carry (inc_chain[i+1])
    );
  end

  // Split latch, sticky overflow and registered outputs
  logic [15:0] latch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q        <= 16'h0000;
      overflow       <= 1'b0;
      displayed_time <= 16'h0000;
      running        <= 1'b0;
      split_active   <= 1'b0;
    end else begin
      if (take_latch) latch_q <= count;
      if (clr_count)             overflow <= 1'b0;
      else if (inc_chain[DIGITS]) overflow <= 1'b1;
      displayed_time <= (state_q == ST_SPLIT) ? latch_q : count;
      running        <= (state_d == ST_RUNNING) || (state_d == ST_SPLIT);
      split_active   <= (state_d == ST_SPLIT);
    end
  end

endmodule
